// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one word-wide memory port between the instruction fetch path
// (read-only) and the data load/store unit. Each access is sequenced through
// IDLE -> ACCESS -> RESP. Data wins a simultaneous request unless data also
// won the previous grant. Misaligned requests are answered without touching
// memory. Accesses that wait too long for mem_ready are aborted with an error.
// Every output comes straight from a flop.

module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic              clk,
    input  logic              rst,

    // instruction fetch side
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic              if_err,
    output logic [31:0]       if_rdata,

    // data load/store side
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic              d_err,
    output logic [31:0]       d_rdata,

    // shared memory port
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Grant owner encoding; last_grant_q also names the owner of the
    // access currently in flight, since it is updated on every grant.
    localparam logic GNT_FETCH = 1'b0;
    localparam logic GNT_DATA  = 1'b1;

    localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT);
    localparam bit              TO_ENABLE = (TIMEOUT != 0);

    state_t            state_q,      state_d;
    logic              last_grant_q, last_grant_d;
    logic [TO_W-1:0]   cnt_q,        cnt_d;

    logic              if_ack_q,     if_ack_d;
    logic              if_err_q,     if_err_d;
    logic [31:0]       if_rdata_q,   if_rdata_d;
    logic              d_ack_q,      d_ack_d;
    logic              d_err_q,      d_err_d;
    logic [31:0]       d_rdata_q,    d_rdata_d;

    logic              mem_req_q,    mem_req_d;
    logic              mem_we_q,     mem_we_d;
    logic [3:0]        mem_be_q,     mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [31:0]       mem_wdata_q,  mem_wdata_d;

    logic              grant_data;
    logic              fetch_bad;
    logic              data_bad;
    logic [ADDR_W-1:0] fetch_word_addr;
    logic [ADDR_W-1:0] data_word_addr;
    logic [TO_W-1:0]   cnt_inc;
    logic              timed_out;

    // Arbitration and request qualification, evaluated from the raw inputs;
    // only consulted while in IDLE.
    always_comb begin
        grant_data      = d_req && !(if_req && (last_grant_q == GNT_DATA));
        fetch_bad       = (if_addr[1:0] != 2'b00);
        data_bad        = (d_addr[1:0] != 2'b00) || (d_be == 4'b0000);
        fetch_word_addr = {if_addr[ADDR_W-1:2], 2'b00};
        data_word_addr  = {d_addr[ADDR_W-1:2], 2'b00};
        cnt_inc         = cnt_q + 1'b1;
        timed_out       = TO_ENABLE && (cnt_inc == TO_LIMIT);
    end

    // Next-state and next-output logic; acks default low so they pulse for
    // exactly the one cycle spent in RESP.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;

        if_ack_d     = 1'b0;
        if_err_d     = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_ack_d      = 1'b0;
        d_err_d      = 1'b0;
        d_rdata_d    = d_rdata_q;

        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    last_grant_d = grant_data ? GNT_DATA : GNT_FETCH;
                    cnt_d        = '0;
                    if (grant_data) begin
                        if (data_bad) begin
                            state_d = RESP;
                            d_ack_d = 1'b1;
                            d_err_d = 1'b1;
                        end else begin
                            state_d     = ACCESS;
                            mem_req_d   = 1'b1;
                            mem_we_d    = d_we;
                            mem_be_d    = d_be;
                            mem_addr_d  = data_word_addr;
                            mem_wdata_d = d_wdata;
                        end
                    end else begin
                        if (fetch_bad) begin
                            state_d  = RESP;
                            if_ack_d = 1'b1;
                            if_err_d = 1'b1;
                        end else begin
                            state_d     = ACCESS;
                            mem_req_d   = 1'b1;
                            mem_we_d    = 1'b0;
                            mem_be_d    = 4'hF;
                            mem_addr_d  = fetch_word_addr;
                            mem_wdata_d = 32'h0;
                        end
                    end
                end
            end

            ACCESS: begin
                if (mem_ready) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (last_grant_q == GNT_DATA) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = mem_rdata;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end else begin
                    if (TO_ENABLE) begin
                        cnt_d = cnt_inc;
                    end
                    if (timed_out) begin
                        state_d   = RESP;
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                        if (last_grant_q == GNT_DATA) begin
                            d_ack_d = 1'b1;
                            d_err_d = 1'b1;
                        end else begin
                            if_ack_d = 1'b1;
                            if_err_d = 1'b1;
                        end
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight
    // without acknowledging it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_DATA;
            cnt_q        <= '0;
            if_ack_q     <= 1'b0;
            if_err_q     <= 1'b0;
            if_rdata_q   <= 32'h0;
            d_ack_q      <= 1'b0;
            d_err_q      <= 1'b0;
            d_rdata_q    <= 32'h0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'h0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            if_ack_q     <= if_ack_d;
            if_err_q     <= if_err_d;
            if_rdata_q   <= if_rdata_d;
            d_ack_q      <= d_ack_d;
            d_err_q      <= d_err_d;
            d_rdata_q    <= d_rdata_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign if_err    = if_err_q;
    assign if_rdata  = if_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed scenarios plus a long randomized run. The random run keeps a
// transaction-level model: when the port is free it picks the winner by the
// priority rule and precomputes the whole expected timeline of that access
// (mem_req window, ack cycle, error, returned word).

module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req, d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    logic        if_ack, if_err, d_ack, d_err;
    logic [31:0] if_rdata, d_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;

    logic        z_if_ack, z_if_err, z_d_ack, z_d_err;
    logic [31:0] z_if_rdata, z_d_rdata;
    logic        z_mem_req, z_mem_we;
    logic [3:0]  z_mem_be;
    logic [31:0] z_mem_addr, z_mem_wdata;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(32), .TIMEOUT(TO), .TO_W(8)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    mem_port_arbiter #(.ADDR_W(32), .TIMEOUT(0), .TO_W(8)) dut0 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(z_if_ack), .if_err(z_if_err), .if_rdata(z_if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(z_d_ack), .d_err(z_d_err), .d_rdata(z_d_rdata),
        .mem_req(z_mem_req), .mem_we(z_mem_we), .mem_be(z_mem_be), .mem_addr(z_mem_addr),
        .mem_wdata(z_mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    // model state for the randomized phase
    int          cyc, free_from;
    bit          last_data;
    bit          t_win;
    int          t_start, t_end, t_ack, t_ready;
    bit          t_err, t_we, t_chk_wdata;
    logic [3:0]  t_be;
    logic [31:0] t_addr, t_wdata, t_rdata;
    bit          f_act, f_gnt, d_act, d_gnt;
    int          f_ok, d_ok;
    logic [31:0] f_a, d_a, d_wd;
    logic [3:0]  d_b;
    bit          d_w;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        mem_ready = 0; mem_rdata = 0;
    endtask

    task automatic doReset();
        clearInputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_if_ack", if_ack, 0);
        checkOutput("rst_d_ack", d_ack, 0);
        checkOutput("rst_if_rdata", if_rdata, 0);
        checkOutput("rst_d_rdata", d_rdata, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_z_mem_req", z_mem_req, 0);
    endtask

    // One cycle of the randomized run: check this cycle's outputs against the
    // scheduled timeline, then drive requesters, arbitrate, drive memory.
    task automatic applyStimulus();
        bit exp_mreq, win_data, bad;
        int k, m;
        logic [31:0] a;

        exp_mreq = (cyc >= t_start) && (cyc <= t_end);
        checkOutput("mem_req", mem_req, exp_mreq);
        if (exp_mreq) begin
            checkOutput("mem_addr", mem_addr, t_addr);
            checkOutput("mem_we", mem_we, t_we);
            checkOutput("mem_be", mem_be, t_be);
            if (t_chk_wdata) checkOutput("mem_wdata", mem_wdata, t_wdata);
        end
        checkOutput("if_ack", if_ack, (cyc == t_ack) && !t_win);
        checkOutput("d_ack", d_ack, (cyc == t_ack) && t_win);
        if (cyc == t_ack) begin
            if (!t_win) begin
                checkOutput("if_err", if_err, t_err);
                if (!t_err) checkOutput("if_rdata", if_rdata, t_rdata);
            end else begin
                checkOutput("d_err", d_err, t_err);
                if (!t_err && !t_we) checkOutput("d_rdata", d_rdata, t_rdata);
            end
        end

        // requesters drop after their ack cycle, sometimes give up early
        if (f_gnt && cyc == t_ack + 1) begin f_act = 0; f_gnt = 0; f_ok = cyc + 1; end
        if (d_gnt && cyc == t_ack + 1) begin d_act = 0; d_gnt = 0; d_ok = cyc + 1; end
        if (!f_act && cyc >= f_ok && $urandom_range(0, 2) == 0) begin
            a = $urandom;
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            f_a = a; f_act = 1;
        end else if (f_act && !f_gnt && $urandom_range(0, 15) == 0) begin
            f_act = 0; f_ok = cyc + 1;
        end
        if (!d_act && cyc >= d_ok && $urandom_range(0, 2) == 0) begin
            a = $urandom;
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            d_a = a; d_w = 1'($urandom_range(0, 1)); d_wd = $urandom;
            d_b = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 7) == 0) d_b = 4'h0;
            d_act = 1;
        end else if (d_act && !d_gnt && $urandom_range(0, 15) == 0) begin
            d_act = 0; d_ok = cyc + 1;
        end
        if_req = f_act; if_addr = f_a;
        d_req = d_act; d_addr = d_a; d_we = d_w; d_be = d_b; d_wdata = d_wd;

        // arbitration when the port is free
        if (cyc >= free_from && (f_act || d_act)) begin
            win_data = d_act && !(f_act && last_data);
            last_data = win_data;
            t_win = win_data;
            if (!win_data) begin
                f_gnt = 1;
                bad = (f_a[1:0] != 2'b00);
                t_addr = {f_a[31:2], 2'b00}; t_we = 0; t_be = 4'hF; t_wdata = 0; t_chk_wdata = 1;
            end else begin
                d_gnt = 1;
                bad = (d_a[1:0] != 2'b00) || (d_b == 4'h0);
                t_addr = {d_a[31:2], 2'b00}; t_we = d_w; t_be = d_b; t_wdata = d_wd; t_chk_wdata = d_w;
            end
            if (bad) begin
                t_err = 1; t_ready = -10; m = 0;
            end else begin
                k = $urandom_range(1, TO + 2);
                if (k <= TO) begin
                    t_err = 0; t_ready = cyc + k; t_rdata = $urandom; m = k;
                end else begin
                    t_err = 1; t_ready = -10; m = TO;
                end
            end
            t_start = cyc + 1;
            t_end = cyc + m;
            t_ack = cyc + m + 1;
            free_from = t_ack + 1;
        end

        // memory responder, with ready noise outside the access window
        if (cyc == t_ready) begin
            mem_ready = 1; mem_rdata = t_rdata;
        end else begin
            mem_ready = ((cyc >= t_start) && (cyc <= t_end)) ? 1'b0 : 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
        end

        tick();
        cyc++;
    endtask

    initial begin
        bit seen_ack;
        rst = 1;
        clearInputs();

        // fetch with immediate ready
        doReset();
        $display("[TB] directed fetch");
        if_req = 1; if_addr = 32'h100; mem_ready = 1; mem_rdata = 32'h00A00093;
        tick();
        checkOutput("t1_mem_req", mem_req, 1);
        checkOutput("t1_mem_addr", mem_addr, 32'h100);
        checkOutput("t1_mem_be", mem_be, 4'hF);
        checkOutput("t1_mem_we", mem_we, 0);
        checkOutput("t1_if_ack_early", if_ack, 0);
        tick();
        checkOutput("t1_mem_req_off", mem_req, 0);
        checkOutput("t1_if_ack", if_ack, 1);
        checkOutput("t1_if_err", if_err, 0);
        checkOutput("t1_if_rdata", if_rdata, 32'h00A00093);
        tick();
        if_req = 0;
        checkOutput("t1_if_ack_pulse", if_ack, 0);

        // first tie after reset goes to fetch, then data
        doReset();
        $display("[TB] directed tie");
        if_req = 1; if_addr = 32'h10; d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h20;
        mem_ready = 1; mem_rdata = 32'hCAFE0001;
        tick();
        checkOutput("t2_first_addr", mem_addr, 32'h10);
        tick();
        checkOutput("t2_if_ack", if_ack, 1);
        checkOutput("t2_d_ack_loser", d_ack, 0);
        tick();
        if_req = 0; mem_rdata = 32'hCAFE0002;
        tick();
        checkOutput("t2_second_addr", mem_addr, 32'h20);
        checkOutput("t2_second_req", mem_req, 1);
        tick();
        checkOutput("t2_d_ack", d_ack, 1);
        checkOutput("t2_d_rdata", d_rdata, 32'hCAFE0002);
        tick();
        d_req = 0; mem_ready = 0;

        // reset in the middle of an access
        tick();
        $display("[TB] directed reset mid-access");
        if_req = 1; if_addr = 32'h40;
        tick();
        checkOutput("t6_mem_req", mem_req, 1);
        rst = 1;
        tick();
        rst = 0;
        checkOutput("t6_mem_req_rst", mem_req, 0);
        checkOutput("t6_no_ack", if_ack, 0);
        if_addr = 32'h44; mem_ready = 1; mem_rdata = 32'h5A5A1234;
        tick();
        checkOutput("t6_new_addr", mem_addr, 32'h44);
        checkOutput("t6_new_no_ack", if_ack, 0);
        tick();
        checkOutput("t6_new_ack", if_ack, 1);
        checkOutput("t6_new_rdata", if_rdata, 32'h5A5A1234);
        tick();
        if_req = 0; mem_ready = 0;

        // timeout disabled: a 1000-cycle wait is not aborted
        doReset();
        $display("[TB] directed no-timeout wait");
        if_req = 1; if_addr = 32'h80;
        seen_ack = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (z_if_ack) seen_ack = 1;
        end
        checkOutput("t5_z_no_ack", seen_ack, 0);
        checkOutput("t5_z_mem_req", z_mem_req, 1);
        mem_ready = 1; mem_rdata = 32'h13579BDF;
        tick();
        checkOutput("t5_z_ack", z_if_ack, 1);
        checkOutput("t5_z_err", z_if_err, 0);
        checkOutput("t5_z_rdata", z_if_rdata, 32'h13579BDF);
        if_req = 0; mem_ready = 0;

        // randomized run against the transaction model
        doReset();
        $display("[TB] randomized run");
        cyc = 0; free_from = 0; last_data = 1; t_win = 0;
        t_start = 1; t_end = 0; t_ack = -10; t_ready = -10;
        t_err = 0; t_we = 0; t_chk_wdata = 0; t_be = 0; t_addr = 0; t_wdata = 0; t_rdata = 0;
        f_act = 0; f_gnt = 0; d_act = 0; d_gnt = 0; f_ok = 0; d_ok = 0;
        f_a = 0; d_a = 0; d_wd = 0; d_b = 0; d_w = 0;
        for (int i = 0; i < 3000; i++) applyStimulus();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
